mem_bus_master_19bit: RTL

- Initiator side of the 19-bit CPU memory interface. Accepts one read or write request at a time from the CPU core over a valid/ready handshake.
- Sequences the memory strobes with address setup and hold cycles: drives addr, rd, wr and write data, and captures read data.
- Returns a response over a valid/ready handshake. Sits between the CPU control unit and the 4K x 19 memory array.

---
 rtl/mem_bus_master_19bit_if.sv | 33 +++
 rtl/mem_bus_master_19bit.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_master_19bit_if.sv
// Bundled CPU request/response and memory strobe signals for mem_bus_master_19bit.
interface mem_bus_master_19bit_if #(
   parameter int unsigned ADDR_W = 12,
   parameter int unsigned DATA_W = 19
);
   logic              req_valid;
   logic              req_ready;
   logic              req_we;
   logic [ADDR_W-1:0] req_addr;
   logic [DATA_W-1:0] req_wdata;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [DATA_W-1:0] rsp_rdata;
   logic              rsp_err;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_rd;
   logic              mem_wr;
   logic [DATA_W-1:0] mem_dout;
   logic [DATA_W-1:0] mem_din;
   logic              busy;

   modport master (
      input  req_valid, req_we, req_addr, req_wdata, rsp_ready, mem_din,
      output req_ready, rsp_valid, rsp_rdata, rsp_err,
      output mem_addr, mem_rd, mem_wr, mem_dout, busy
   );

   modport slave (
      output req_valid, req_we, req_addr, req_wdata, rsp_ready, mem_din,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err,
      input  mem_addr, mem_rd, mem_wr, mem_dout, busy
   );
endinterface

// File: rtl/mem_bus_master_19bit.sv
// Memory bus initiator: sequences setup/strobe/hold for one CPU request at a time.
// Optional write read-back check is built when MEM_WRITE_VERIFY_EN is defined.
module mem_bus_master_19bit #(
   parameter int unsigned ADDR_W     = 12,
   parameter int unsigned DATA_W     = 19,
   parameter int unsigned STROBE_CYC = 1
) (
   input logic                    clk,
   input logic                    rst_n,
   mem_bus_master_19bit_if.master bus
);

   localparam int unsigned      CNT_W    = 4;
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(STROBE_CYC - 1);

`ifdef MEM_WRITE_VERIFY_EN
   typedef enum logic [2:0] {
      S_IDLE, S_SETUP, S_STROBE, S_HOLD, S_RESP, S_VSETUP, S_VSTROBE, S_VHOLD
   } state_t;
`else
   typedef enum logic [2:0] {
      S_IDLE, S_SETUP, S_STROBE, S_HOLD, S_RESP
   } state_t;
`endif

   state_t            r_state,      w_state_nxt;
   logic [CNT_W-1:0]  r_cnt,        w_cnt_nxt;
   logic              r_we,         w_we_nxt;
   logic [ADDR_W-1:0] r_addr,       w_addr_nxt;
   logic [DATA_W-1:0] r_wdata,      w_wdata_nxt;
   logic [ADDR_W-1:0] r_mem_addr,   w_mem_addr_nxt;
   logic [DATA_W-1:0] r_mem_dout,   w_mem_dout_nxt;
   logic              r_mem_rd,     w_mem_rd_nxt;
   logic              r_mem_wr,     w_mem_wr_nxt;
   logic [DATA_W-1:0] r_cap,        w_cap_nxt;
   logic              r_rsp_valid,  w_rsp_valid_nxt;
   logic [DATA_W-1:0] r_rsp_rdata,  w_rsp_rdata_nxt;
   logic              r_req_ready;
   logic              r_busy;
`ifdef MEM_WRITE_VERIFY_EN
   logic              r_rsp_err,    w_rsp_err_nxt;
`endif

   // Next state plus the registered decode of the bus outputs for the current state
   always_comb begin
      w_state_nxt     = r_state;
      w_cnt_nxt       = r_cnt;
      w_we_nxt        = r_we;
      w_addr_nxt      = r_addr;
      w_wdata_nxt     = r_wdata;
      w_mem_addr_nxt  = r_mem_addr;
      w_mem_dout_nxt  = r_mem_dout;
      w_mem_rd_nxt    = 1'b0;
      w_mem_wr_nxt    = 1'b0;
      w_cap_nxt       = r_cap;
      w_rsp_valid_nxt = 1'b0;
      w_rsp_rdata_nxt = r_rsp_rdata;
`ifdef MEM_WRITE_VERIFY_EN
      w_rsp_err_nxt   = r_rsp_err;
`endif

      // last edge with the read strobe high leaves the final sample in r_cap
      if (r_mem_rd) w_cap_nxt = bus.mem_din;

      unique case (r_state)
         S_IDLE: begin
            if (bus.req_valid && r_req_ready) begin
               w_state_nxt = S_SETUP;
               w_we_nxt    = bus.req_we;
               w_addr_nxt  = bus.req_addr;
               w_wdata_nxt = bus.req_wdata;
`ifdef MEM_WRITE_VERIFY_EN
               w_rsp_err_nxt = 1'b0;
`endif
            end
         end
         S_SETUP: begin
            w_state_nxt    = S_STROBE;
            w_cnt_nxt      = CNT_INIT;
            w_mem_addr_nxt = r_addr;
            w_mem_dout_nxt = r_we ? r_wdata : '0;
         end
         S_STROBE: begin
            w_mem_rd_nxt = ~r_we;
            w_mem_wr_nxt = r_we;
            if (r_cnt == '0) w_state_nxt = S_HOLD;
            else             w_cnt_nxt   = r_cnt - CNT_W'(1);
         end
         S_HOLD: begin
`ifdef MEM_WRITE_VERIFY_EN
            w_state_nxt = r_we ? S_VSETUP : S_RESP;
`else
            w_state_nxt = S_RESP;
`endif
         end
         S_RESP: begin
            if (r_rsp_valid) begin
               if (bus.rsp_ready) w_state_nxt     = S_IDLE;
               else               w_rsp_valid_nxt = 1'b1;
            end else begin
               w_rsp_valid_nxt = 1'b1;
               w_rsp_rdata_nxt = r_we ? '0 : r_cap;
`ifdef MEM_WRITE_VERIFY_EN
               w_rsp_err_nxt   = r_we && (r_cap != r_wdata);
`endif
            end
         end
`ifdef MEM_WRITE_VERIFY_EN
         S_VSETUP: begin
            w_state_nxt = S_VSTROBE;
            w_cnt_nxt   = CNT_INIT;
         end
         S_VSTROBE: begin
            w_mem_rd_nxt = 1'b1;
            if (r_cnt == '0) w_state_nxt = S_VHOLD;
            else             w_cnt_nxt   = r_cnt - CNT_W'(1);
         end
         S_VHOLD: begin
            w_state_nxt = S_RESP;
         end
`endif
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // State and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_cnt       <= '0;
         r_we        <= 1'b0;
         r_addr      <= '0;
         r_wdata     <= '0;
         r_mem_addr  <= '0;
         r_mem_dout  <= '0;
         r_mem_rd    <= 1'b0;
         r_mem_wr    <= 1'b0;
         r_cap       <= '0;
         r_rsp_valid <= 1'b0;
         r_rsp_rdata <= '0;
         r_req_ready <= 1'b1;
         r_busy      <= 1'b0;
`ifdef MEM_WRITE_VERIFY_EN
         r_rsp_err   <= 1'b0;
`endif
      end else begin
         r_state     <= w_state_nxt;
         r_cnt       <= w_cnt_nxt;
         r_we        <= w_we_nxt;
         r_addr      <= w_addr_nxt;
         r_wdata     <= w_wdata_nxt;
         r_mem_addr  <= w_mem_addr_nxt;
         r_mem_dout  <= w_mem_dout_nxt;
         r_mem_rd    <= w_mem_rd_nxt;
         r_mem_wr    <= w_mem_wr_nxt;
         r_cap       <= w_cap_nxt;
         r_rsp_valid <= w_rsp_valid_nxt;
         r_rsp_rdata <= w_rsp_rdata_nxt;
         r_req_ready <= (w_state_nxt == S_IDLE);
         r_busy      <= (w_state_nxt != S_IDLE);
`ifdef MEM_WRITE_VERIFY_EN
         r_rsp_err   <= w_rsp_err_nxt;
`endif
      end
   end

   assign bus.req_ready = r_req_ready;
   assign bus.busy      = r_busy;
   assign bus.rsp_valid = r_rsp_valid;
   assign bus.rsp_rdata = r_rsp_rdata;
   assign bus.mem_addr  = r_mem_addr;
   assign bus.mem_rd    = r_mem_rd;
   assign bus.mem_wr    = r_mem_wr;
   assign bus.mem_dout  = r_mem_dout;
`ifdef MEM_WRITE_VERIFY_EN
   assign bus.rsp_err   = r_rsp_err;
`else
   assign bus.rsp_err   = 1'b0;
`endif

endmodule
